// File: rtl/read_tag_scheduler_pkg.sv
// Shared types for the read tag scheduler: the command line carried per tag,
// the command type enum, the free-tag vector and default pool sizes.
package read_tag_scheduler_pkg;

  localparam int NUM_TAGS_DEF   = 32;
  localparam int CREDIT_MAX_DEF = 64;

  typedef enum logic [1:0] {
    CMD_READ = 2'd0,
    CMD_WED  = 2'd1
  } cmd_type_e;

  typedef struct packed {
    cmd_type_e    cmd_type;
    logic [63:0]  address;
    logic [15:0]  size;
    logic [7:0]   engine_id;
  } CommandTagLine;

  typedef logic [NUM_TAGS_DEF-1:0] TagFreeVector;

endpackage

// File: rtl/read_tag_scheduler_arbiter.sv
// One-hot request arbiter for the read tag scheduler.
// Default build: round-robin, search starts one past the last winner.
// With STRICT_PRIORITY_EN defined: fixed priority, lowest index wins, no pointer.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic               clock,
  input  logic               rstn,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);

  logic found_s;

`ifdef STRICT_PRIORITY_EN

  // Fixed priority: first set request from index 0 upward wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found_s   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found_s && req[i]) begin
        grant[i]  = 1'b1;
        grant_idx = IDX_W'(i);
        found_s   = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

`else

  logic [IDX_W-1:0] ptr_r;
  logic [IDX_W-1:0] cand_s;

  // Round-robin search starting at ptr_r + 1, wrapping to 0.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found_s   = 1'b0;
    cand_s    = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand_s = IDX_W'((int'(ptr_r) + i) % NUM_REQ);
      if (!found_s && req[cand_s]) begin
        grant[cand_s] = 1'b1;
        grant_idx     = cand_s;
        found_s       = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Pointer remembers the last winner and moves only when a grant is made.
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      ptr_r <= IDX_W'(NUM_REQ - 1);
    end else if (found_s) begin
      ptr_r <= grant_idx;
    end else begin
      ptr_r <= ptr_r;
    end
  end

`endif

endmodule

// File: rtl/read_tag_scheduler.sv
// Read tag scheduler: arbitrates engine read/WED commands onto the PSL
// command port, allocates tags, tracks credits and serves per-tag lookups
// for buffer writes. Optional macro STRICT_PRIORITY_EN selects fixed
// priority arbitration instead of round-robin.
module read_tag_scheduler
  import read_tag_scheduler_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int NUM_TAGS   = NUM_TAGS_DEF,
  parameter int TAG_W      = 8,
  parameter int CREDIT_MAX = CREDIT_MAX_DEF
) (
  input  logic                        clock,
  input  logic                        rstn,
  input  logic                        enabled,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  CommandTagLine [NUM_REQ-1:0] req_cmd,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        cmd_out_valid,
  output logic [TAG_W-1:0]            cmd_out_tag,
  output CommandTagLine               cmd_out_line,
  input  logic                        resp_valid,
  input  logic [TAG_W-1:0]            resp_tag,
  input  logic                        resp_done,
  input  logic                        buf_write_valid,
  input  logic [TAG_W-1:0]            buf_write_tag,
  output CommandTagLine               tag_line_out,
  output logic [$clog2(NUM_TAGS):0]   outstanding,
  output logic                        idle,
  output logic                        resp_error,
  output logic                        protocol_error
);

  localparam int IDX_W = $clog2(NUM_TAGS);
  localparam int CNT_W = IDX_W + 1;
  localparam int CRD_W = $clog2(CREDIT_MAX + 1);
  localparam int REQ_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_TAGS-1:0] free_r, free_next_s;
  logic [CRD_W-1:0]    credits_r;
  logic [CNT_W-1:0]    outstanding_r;
  CommandTagLine       table_r [NUM_TAGS];

  logic                cmd_out_valid_r;
  logic [TAG_W-1:0]    cmd_out_tag_r;
  CommandTagLine       cmd_out_line_r;
  CommandTagLine       tag_line_r;
  logic                resp_error_r, protocol_error_r;

  logic [IDX_W-1:0]    alloc_tag_s;
  logic                tag_avail_s, can_grant_s, grant_any_s;
  logic [NUM_REQ-1:0]  arb_req_s, grant_s;
  logic [REQ_W-1:0]    grant_idx_s;
  logic                resp_hit_s, resp_bad_s, bw_in_range_s;
  logic [IDX_W-1:0]    resp_idx_s, bw_idx_s;

  // Lowest-index free tag; only tags free at the start of the cycle qualify.
  always_comb begin
    alloc_tag_s = '0;
    tag_avail_s = 1'b0;
    for (int t = NUM_TAGS - 1; t >= 0; t--) begin
      if (free_r[t]) begin
        alloc_tag_s = IDX_W'(t);
        tag_avail_s = 1'b1;
      end else begin
        alloc_tag_s = alloc_tag_s;
      end
    end
  end

  assign can_grant_s = enabled && tag_avail_s && (credits_r != '0);
  assign arb_req_s   = req_valid & {NUM_REQ{can_grant_s}};
  assign grant_any_s = |grant_s;
  assign req_ready   = grant_s;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (REQ_W)
  ) u_arb (
    .clock     (clock),
    .rstn      (rstn),
    .req       (arb_req_s),
    .grant     (grant_s),
    .grant_idx (grant_idx_s)
  );

  // Classify the response and buffer-write tags against the pool.
  always_comb begin
    resp_idx_s    = resp_tag[IDX_W-1:0];
    bw_idx_s      = buf_write_tag[IDX_W-1:0];
    bw_in_range_s = (buf_write_tag < TAG_W'(NUM_TAGS));
    if (resp_valid && (resp_tag < TAG_W'(NUM_TAGS))) begin
      resp_hit_s = !free_r[resp_idx_s];
    end else begin
      resp_hit_s = 1'b0;
    end
    resp_bad_s = resp_valid && !resp_hit_s;
  end

  // Next free vector: a response frees its tag, a grant claims the allocated tag.
  always_comb begin
    free_next_s = free_r;
    if (resp_hit_s) begin
      free_next_s[resp_idx_s] = 1'b1;
    end else begin
      free_next_s = free_next_s;
    end
    if (grant_any_s) begin
      free_next_s[alloc_tag_s] = 1'b0;
    end else begin
      free_next_s = free_next_s;
    end
  end

  // Tag pool, credit and outstanding bookkeeping plus sticky error flags.
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      free_r           <= '1;
      credits_r        <= CRD_W'(CREDIT_MAX);
      outstanding_r    <= '0;
      resp_error_r     <= 1'b0;
      protocol_error_r <= 1'b0;
    end else begin
      free_r           <= free_next_s;
      credits_r        <= credits_r + CRD_W'(resp_hit_s) - CRD_W'(grant_any_s);
      outstanding_r    <= outstanding_r + CNT_W'(grant_any_s) - CNT_W'(resp_hit_s);
      resp_error_r     <= resp_error_r | (resp_hit_s && !resp_done);
      protocol_error_r <= protocol_error_r | resp_bad_s;
    end
  end

  // Command issue register: one-cycle strobe carrying the winner's command.
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      cmd_out_valid_r <= 1'b0;
      cmd_out_tag_r   <= '0;
      cmd_out_line_r  <= '0;
    end else if (grant_any_s) begin
      cmd_out_valid_r <= 1'b1;
      cmd_out_tag_r   <= TAG_W'(alloc_tag_s);
      cmd_out_line_r  <= req_cmd[grant_idx_s];
    end else begin
      cmd_out_valid_r <= 1'b0;
      cmd_out_tag_r   <= cmd_out_tag_r;
      cmd_out_line_r  <= cmd_out_line_r;
    end
  end

  // Tag table write on allocation; entries survive the free so late data still resolves.
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      for (int t = 0; t < NUM_TAGS; t++) begin
        table_r[t] <= '0;
      end
    end else if (grant_any_s) begin
      table_r[alloc_tag_s] <= req_cmd[grant_idx_s];
    end else begin
      table_r[alloc_tag_s] <= table_r[alloc_tag_s];
    end
  end

  // Lookup register: loads on a buffer write, holds otherwise.
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      tag_line_r <= '0;
    end else if (buf_write_valid) begin
      tag_line_r <= bw_in_range_s ? table_r[bw_idx_s] : '0;
    end else begin
      tag_line_r <= tag_line_r;
    end
  end

  assign cmd_out_valid  = cmd_out_valid_r;
  assign cmd_out_tag    = cmd_out_tag_r;
  assign cmd_out_line   = cmd_out_line_r;
  assign tag_line_out   = tag_line_r;
  assign outstanding    = outstanding_r;
  assign idle           = (outstanding_r == '0);
  assign resp_error     = resp_error_r;
  assign protocol_error = protocol_error_r;

endmodule

// File: tb/tb_read_tag_scheduler.sv
// Directed self-checking bench for read_tag_scheduler. A second instance
// with CREDIT_MAX = 4 shares the stimulus and is checked in the credit test.
module tb_read_tag_scheduler;
  import read_tag_scheduler_pkg::*;

  logic                clock = 1'b0;
  logic                rstn;
  logic                enabled;
  logic [3:0]          req_valid;
  CommandTagLine [3:0] req_cmd;
  logic                resp_valid, resp_done, buf_write_valid;
  logic [7:0]          resp_tag, buf_write_tag;

  logic [3:0]    req_ready, req_ready_c;
  logic          cmd_out_valid, cmd_out_valid_c;
  logic [7:0]    cmd_out_tag, cmd_out_tag_c;
  CommandTagLine cmd_out_line, cmd_out_line_c, tag_line_out, tag_line_out_c;
  logic [5:0]    outstanding, outstanding_c;
  logic          idle, idle_c, resp_error, resp_error_c, protocol_error, protocol_error_c;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  read_tag_scheduler dut (
    .clock(clock), .rstn(rstn), .enabled(enabled), .req_valid(req_valid), .req_cmd(req_cmd),
    .req_ready(req_ready), .cmd_out_valid(cmd_out_valid), .cmd_out_tag(cmd_out_tag),
    .cmd_out_line(cmd_out_line), .resp_valid(resp_valid), .resp_tag(resp_tag),
    .resp_done(resp_done), .buf_write_valid(buf_write_valid), .buf_write_tag(buf_write_tag),
    .tag_line_out(tag_line_out), .outstanding(outstanding), .idle(idle),
    .resp_error(resp_error), .protocol_error(protocol_error)
  );

  read_tag_scheduler #(.CREDIT_MAX(4)) dut_c (
    .clock(clock), .rstn(rstn), .enabled(enabled), .req_valid(req_valid), .req_cmd(req_cmd),
    .req_ready(req_ready_c), .cmd_out_valid(cmd_out_valid_c), .cmd_out_tag(cmd_out_tag_c),
    .cmd_out_line(cmd_out_line_c), .resp_valid(resp_valid), .resp_tag(resp_tag),
    .resp_done(resp_done), .buf_write_valid(buf_write_valid), .buf_write_tag(buf_write_tag),
    .tag_line_out(tag_line_out_c), .outstanding(outstanding_c), .idle(idle_c),
    .resp_error(resp_error_c), .protocol_error(protocol_error_c)
  );

  function automatic CommandTagLine mk(cmd_type_e t, logic [63:0] a, logic [7:0] e);
    CommandTagLine l;
    l.cmd_type  = t;
    l.address   = a;
    l.size      = 16'd128;
    l.engine_id = e;
    return l;
  endfunction

  task automatic drive_idle();
    req_valid       = 4'b0000;
    resp_valid      = 1'b0;
    resp_tag        = 8'd0;
    resp_done       = 1'b1;
    buf_write_valid = 1'b0;
    buf_write_tag   = 8'd0;
    enabled         = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    drive_idle();
    rstn = 1'b0;
    repeat (2) @(negedge clock);
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    total++; if (outstanding !== 6'd0) begin bad++; $display("FAIL reset_outstanding got=%0d exp=0", outstanding); end
    total++; if (idle !== 1'b1) begin bad++; $display("FAIL reset_idle got=%0b exp=1", idle); end
    total++; if (cmd_out_valid !== 1'b0) begin bad++; $display("FAIL reset_cmd_valid got=%0b exp=0", cmd_out_valid); end
    total++; if ({resp_error, protocol_error} !== 2'b00) begin bad++; $display("FAIL reset_errors got=%0b%0b exp=00", resp_error, protocol_error); end
    total++; if (tag_line_out !== CommandTagLine'(0)) begin bad++; $display("FAIL reset_tag_line got=%0h exp=0", tag_line_out); end
  endtask

  task automatic test_single();
    CommandTagLine exp_l;
    do_reset();
    exp_l = mk(CMD_READ, 64'h1000, 8'd2);
    @(negedge clock); req_valid = 4'b0100; req_cmd[2] = exp_l; #1;
    total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL single_ready got=%b exp=0100", req_ready); end
    @(negedge clock); req_valid = 4'b0000; #1;
    total++; if (cmd_out_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%0b exp=1", cmd_out_valid); end
    total++; if (cmd_out_tag !== 8'd0) begin bad++; $display("FAIL single_tag got=%0d exp=0", cmd_out_tag); end
    total++; if (cmd_out_line !== exp_l) begin bad++; $display("FAIL single_line got=%0h exp=%0h", cmd_out_line, exp_l); end
    total++; if (outstanding !== 6'd1) begin bad++; $display("FAIL single_outstanding got=%0d exp=1", outstanding); end
    total++; if (idle !== 1'b0) begin bad++; $display("FAIL single_idle got=%0b exp=0", idle); end
    @(negedge clock); #1;
    total++; if (cmd_out_valid !== 1'b0) begin bad++; $display("FAIL single_strobe_len got=%0b exp=0", cmd_out_valid); end
  endtask

  task automatic test_round_robin();
    int exp_e;
    do_reset();
    for (int i = 0; i < 4; i++) req_cmd[i] = mk(CMD_READ, 64'h100 * i, 8'(i));
    for (int k = 0; k <= 8; k++) begin
      @(negedge clock);
      if (k > 0) begin
`ifdef STRICT_PRIORITY_EN
        exp_e = 0;
`else
        exp_e = (k - 1) % 4;
`endif
        #1;
        total++; if (cmd_out_tag !== 8'(k - 1) || cmd_out_line.engine_id !== 8'(exp_e) || cmd_out_valid !== 1'b1)
          begin bad++; $display("FAIL rr_issue k=%0d got tag=%0d eng=%0d exp tag=%0d eng=%0d", k - 1, cmd_out_tag, cmd_out_line.engine_id, k - 1, exp_e); end
      end
      if (k < 8) begin
`ifdef STRICT_PRIORITY_EN
        exp_e = 0;
`else
        exp_e = k % 4;
`endif
        req_valid = 4'b1111; #1;
        total++; if (req_ready !== (4'b0001 << exp_e)) begin bad++; $display("FAIL rr_grant k=%0d got=%b exp=%b", k, req_ready, 4'b0001 << exp_e); end
      end else begin
        req_valid = 4'b0000;
      end
    end
  endtask

  task automatic test_tag_exhaust();
    do_reset();
    req_cmd[0] = mk(CMD_READ, 64'h2000, 8'd0);
    for (int k = 0; k < 32; k++) begin
      @(negedge clock); req_valid = 4'b0001; #1;
      total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL exhaust_grant k=%0d got=%b exp=0001", k, req_ready); end
    end
    @(negedge clock); #1;
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL exhaust_33rd got=%b exp=0000", req_ready); end
    total++; if (outstanding !== 6'd32) begin bad++; $display("FAIL exhaust_outstanding got=%0d exp=32", outstanding); end
    @(negedge clock); resp_valid = 1'b1; resp_tag = 8'd5; resp_done = 1'b1; #1;
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL exhaust_resp_cycle got=%b exp=0000", req_ready); end
    @(negedge clock); resp_valid = 1'b0; #1;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL exhaust_after_resp got=%b exp=0001", req_ready); end
    total++; if (outstanding !== 6'd31) begin bad++; $display("FAIL exhaust_freed got=%0d exp=31", outstanding); end
    @(negedge clock); req_valid = 4'b0000; #1;
    total++; if (cmd_out_valid !== 1'b1 || cmd_out_tag !== 8'd5) begin bad++; $display("FAIL exhaust_reuse got v=%0b tag=%0d exp v=1 tag=5", cmd_out_valid, cmd_out_tag); end
  endtask

  task automatic test_credits();
    do_reset();
    req_cmd[0] = mk(CMD_READ, 64'h3000, 8'd0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clock); req_valid = 4'b0001; #1;
      total++; if (req_ready_c !== ((k < 4) ? 4'b0001 : 4'b0000)) begin bad++; $display("FAIL credit_grant k=%0d got=%b", k, req_ready_c); end
    end
    total++; if (outstanding_c !== 6'd4) begin bad++; $display("FAIL credit_stall_out got=%0d exp=4", outstanding_c); end
    @(negedge clock); resp_valid = 1'b1; resp_tag = 8'd0; resp_done = 1'b1; #1;
    total++; if (req_ready_c !== 4'b0000) begin bad++; $display("FAIL credit_resp_cycle got=%b exp=0000", req_ready_c); end
    @(negedge clock); resp_tag = 8'd1; #1;
    total++; if (req_ready_c !== 4'b0001 || outstanding_c !== 6'd3) begin bad++; $display("FAIL credit_issue_resp got ready=%b out=%0d exp ready=0001 out=3", req_ready_c, outstanding_c); end
    @(negedge clock); resp_valid = 1'b0; #1;
    total++; if (req_ready_c !== 4'b0001 || outstanding_c !== 6'd3) begin bad++; $display("FAIL credit_net got ready=%b out=%0d exp ready=0001 out=3", req_ready_c, outstanding_c); end
    total++; if (cmd_out_valid_c !== 1'b1 || cmd_out_tag_c !== 8'd0) begin bad++; $display("FAIL credit_tag0 got v=%0b tag=%0d exp v=1 tag=0", cmd_out_valid_c, cmd_out_tag_c); end
    @(negedge clock); #1;
    total++; if (req_ready_c !== 4'b0000 || outstanding_c !== 6'd4) begin bad++; $display("FAIL credit_one_more got ready=%b out=%0d exp ready=0000 out=4", req_ready_c, outstanding_c); end
    total++; if (cmd_out_tag_c !== 8'd1) begin bad++; $display("FAIL credit_tag1 got=%0d exp=1", cmd_out_tag_c); end
    @(negedge clock); req_valid = 4'b0000; #1;
    total++; if ({resp_error_c, protocol_error_c} !== 2'b00) begin bad++; $display("FAIL credit_errors got=%0b%0b exp=00", resp_error_c, protocol_error_c); end
  endtask

  task automatic test_errors();
    do_reset();
    @(negedge clock); resp_valid = 1'b1; resp_tag = 8'd9; resp_done = 1'b1;
    @(negedge clock); resp_valid = 1'b0; #1;
    total++; if (protocol_error !== 1'b1 || outstanding !== 6'd0 || resp_error !== 1'b0) begin bad++; $display("FAIL err_free_tag got perr=%0b out=%0d rerr=%0b exp 1/0/0", protocol_error, outstanding, resp_error); end
    do_reset(); #1;
    total++; if (protocol_error !== 1'b0) begin bad++; $display("FAIL err_clear got=%0b exp=0", protocol_error); end
    @(negedge clock); resp_valid = 1'b1; resp_tag = 8'd40;
    @(negedge clock); resp_valid = 1'b0; #1;
    total++; if (protocol_error !== 1'b1) begin bad++; $display("FAIL err_range got=%0b exp=1", protocol_error); end
    do_reset();
    req_cmd[1] = mk(CMD_READ, 64'h4000, 8'd1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clock); req_valid = 4'b0010;
    end
    @(negedge clock); req_valid = 4'b0000; resp_valid = 1'b1; resp_tag = 8'd3; resp_done = 1'b0;
    @(negedge clock); resp_valid = 1'b0; resp_done = 1'b1; #1;
    total++; if (resp_error !== 1'b1 || outstanding !== 6'd3 || protocol_error !== 1'b0) begin bad++; $display("FAIL err_not_done got rerr=%0b out=%0d perr=%0b exp 1/3/0", resp_error, outstanding, protocol_error); end
    @(negedge clock); req_valid = 4'b0010;
    @(negedge clock); req_valid = 4'b0000; #1;
    total++; if (cmd_out_tag !== 8'd3) begin bad++; $display("FAIL err_tag3_freed got=%0d exp=3", cmd_out_tag); end
    @(negedge clock); enabled = 1'b0; req_valid = 4'b0010; #1;
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL disabled_ready got=%b exp=0000", req_ready); end
    @(negedge clock); resp_valid = 1'b1; resp_tag = 8'd0;
    @(negedge clock); resp_valid = 1'b0; req_valid = 4'b0000; enabled = 1'b1; #1;
    total++; if (outstanding !== 6'd3 || resp_error !== 1'b1) begin bad++; $display("FAIL disabled_resp got out=%0d rerr=%0b exp 3/1", outstanding, resp_error); end
  endtask

  task automatic test_lookup();
    CommandTagLine exp_l;
    do_reset();
    exp_l = mk(CMD_WED, 64'hABC0, 8'd3);
    req_cmd[3] = exp_l;
    @(negedge clock); req_valid = 4'b1000;
    @(negedge clock); req_valid = 4'b0000; buf_write_valid = 1'b1; buf_write_tag = 8'd0;
    @(negedge clock); buf_write_valid = 1'b0; buf_write_tag = 8'd1; #1;
    total++; if (tag_line_out.cmd_type !== CMD_WED || tag_line_out !== exp_l) begin bad++; $display("FAIL lookup_wed got=%0h exp=%0h", tag_line_out, exp_l); end
    @(negedge clock); #1;
    total++; if (tag_line_out !== exp_l) begin bad++; $display("FAIL lookup_hold got=%0h exp=%0h", tag_line_out, exp_l); end
    buf_write_valid = 1'b1;
    @(negedge clock); buf_write_valid = 1'b0; #1;
    total++; if (tag_line_out !== CommandTagLine'(0)) begin bad++; $display("FAIL lookup_tag1 got=%0h exp=0", tag_line_out); end
    resp_valid = 1'b1; resp_tag = 8'd0;
    @(negedge clock); resp_valid = 1'b0; buf_write_valid = 1'b1; buf_write_tag = 8'd0;
    @(negedge clock); buf_write_valid = 1'b0; #1;
    total++; if (tag_line_out !== exp_l || outstanding !== 6'd0) begin bad++; $display("FAIL lookup_persist got=%0h out=%0d exp=%0h out=0", tag_line_out, outstanding, exp_l); end
    @(negedge clock); req_valid = 4'b1000;
    @(negedge clock); req_valid = 4'b0000; #1;
    total++; if (outstanding !== 6'd1) begin bad++; $display("FAIL midreset_pre got=%0d exp=1", outstanding); end
    #2 rstn = 1'b0; #1;
    total++; if (outstanding !== 6'd0 || idle !== 1'b1 || tag_line_out !== CommandTagLine'(0)) begin bad++; $display("FAIL midreset_state got out=%0d idle=%0b line=%0h exp 0/1/0", outstanding, idle, tag_line_out); end
    @(negedge clock); rstn = 1'b1;
    @(negedge clock); resp_valid = 1'b1; resp_tag = 8'd0;
    @(negedge clock); resp_valid = 1'b0; #1;
    total++; if (protocol_error !== 1'b1 || outstanding !== 6'd0) begin bad++; $display("FAIL midreset_old_tag got perr=%0b out=%0d exp 1/0", protocol_error, outstanding); end
  endtask

  initial begin
    rstn = 1'b0;
    drive_idle();
    for (int i = 0; i < 4; i++) req_cmd[i] = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_tag_exhaust();
    test_credits();
    test_errors();
    test_lookup();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
